vq6_element_selector: RTL and testbench

//  Vector quantizer for the 6-element unit DAC; it closes the mismatch-shaping loop.
//  It takes a thermometer count (0..6) from the delta-sigma modulator and a snapshot of the loop-filter outputs SFM5..SFM0.
//  It turns on the `code` elements with the largest SFM values: the least-used elements.
//  The result is the selection vector sv, which feeds both the loop filter SV input and the unit-element drivers.

---
 rtl/dac_dig_pkg.sv | 39 +++
 rtl/argmax6_masked.sv | 61 ++++++
 rtl/vq6_element_selector.sv | 150 +++++++++++++++
 tb/tb_vq6_element_selector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_dig_pkg.sv
// ---------------------------------------------------------------------------
// dac_dig_pkg
// Shared definitions for the unit-element DAC digital back end.
//   - element count and data widths
//   - the selector FSM state encoding
//   - the packed SFM array type used for the snapshot registers
//   - the candidate record passed through the argmax compare tree
//   - clampCode(): saturates a thermometer count at the number of elements
// ---------------------------------------------------------------------------
package dac_dig_pkg;

  localparam int N_ELEM = 6;
  localparam int W_SFM  = 6;
  localparam int W_CODE = 3;
  localparam logic [W_CODE-1:0] CODE_MAX = 3'd6;

  // Selector FSM: wait for a sample, then pick one element per clock.
  typedef enum logic {
    IDLE = 1'b0,
    SEL  = 1'b1
  } state_t;

  // Element i lives in slice [i], so {sfm5, ..., sfm0} packs directly.
  typedef logic [N_ELEM-1:0][W_SFM-1:0] sfm_arr_t;

  // One contender inside the argmax tree. vld=0 means the element is
  // already selected and must never win.
  typedef struct packed {
    logic             vld;
    logic [2:0]       idx;
    logic [W_SFM-1:0] val;
  } cand_t;

  // Codes above the element count cannot be honoured; turn everything on.
  function automatic logic [W_CODE-1:0] clampCode(input logic [W_CODE-1:0] c);
    return (c > CODE_MAX) ? CODE_MAX : c;
  endfunction

endpackage

// File: rtl/argmax6_masked.sv
// ---------------------------------------------------------------------------
// argmax6_masked
// Purely combinational: finds the largest unmasked value among six unsigned
// SFM values. Ties resolve to the lowest element index.
// Ports:
//   i_vals    in  6*W_SFM  packed values, element i at [i*W_SFM +: W_SFM]
//   i_mask    in  6        1 = element already taken, excluded from the search
//   o_idx     out 3        index of the winning element
//   o_onehot  out 6        one-hot of the winner (all zero if every element
//                          is masked)
// ---------------------------------------------------------------------------
module argmax6_masked
  import dac_dig_pkg::*;
(
  input  logic [N_ELEM*W_SFM-1:0] i_vals,
  input  logic [N_ELEM-1:0]       i_mask,
  output logic [2:0]              o_idx,
  output logic [N_ELEM-1:0]       o_onehot
);

  cand_t w_cand [N_ELEM];
  cand_t w_lvl1 [3];
  cand_t w_lvl2a;
  cand_t w_win;

  // Keeps 'a' on equal values. Callers always pass the lower-index
  // candidate as 'a', which is what gives lowest-index-wins on ties.
  function automatic cand_t pickCand(input cand_t a, input cand_t b);
    if (a.vld && (!b.vld || (a.val >= b.val))) begin
      return a;
    end
    return b;
  endfunction

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      w_cand[i].vld = ~i_mask[i];
      w_cand[i].idx = 3'(i);
      w_cand[i].val = i_vals[i*W_SFM +: W_SFM];
    end
  end

  // Level 1: three pairwise compares. Level 2: fold the three pair winners,
  // again keeping the lower-index side first.
  always_comb begin
    w_lvl1[0] = pickCand(w_cand[0], w_cand[1]);
    w_lvl1[1] = pickCand(w_cand[2], w_cand[3]);
    w_lvl1[2] = pickCand(w_cand[4], w_cand[5]);
    w_lvl2a   = pickCand(w_lvl1[0], w_lvl1[1]);
    w_win     = pickCand(w_lvl2a, w_lvl1[2]);
  end

  always_comb begin
    o_idx    = w_win.idx;
    o_onehot = '0;
    if (w_win.vld) begin
      o_onehot = N_ELEM'(1) << w_win.idx;
    end
  end

endmodule

// File: rtl/vq6_element_selector.sv
// ---------------------------------------------------------------------------
// vq6_element_selector
// Vector quantizer for the 6-element unit DAC, closing the mismatch-shaping
// loop. For each accepted sample it turns on the 'code' elements whose
// loop-filter outputs (SFM) are largest, i.e. the least-used elements.
// One element is chosen per clock against a snapshot of the SFM inputs.
// Ports:
//   clk       in   1       clock, rising edge
//   rstn      in   1       asynchronous active-low reset
//   in_valid  in   1       code/SFM sample valid
//   in_ready  out  1       idle; sample accepted on in_valid & in_ready
//   code      in   3       number of elements to turn on (0..6, >6 saturates)
//   sfm5..0   in   6 each  unsigned loop-filter outputs per element
//   sv        out  6       selection vector, bit i = element i on
//   sv_valid  out  1       one-cycle strobe: new sv present (filter advance)
//   sat_err   out  1       sticky: a code above 6 has been received
// ---------------------------------------------------------------------------
module vq6_element_selector
  import dac_dig_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_CODE-1:0] code,
  input  logic [W_SFM-1:0]  sfm5,
  input  logic [W_SFM-1:0]  sfm4,
  input  logic [W_SFM-1:0]  sfm3,
  input  logic [W_SFM-1:0]  sfm2,
  input  logic [W_SFM-1:0]  sfm1,
  input  logic [W_SFM-1:0]  sfm0,
  output logic [N_ELEM-1:0] sv,
  output logic              sv_valid,
  output logic              sat_err
);

  state_t              r_state;
  state_t              w_stateNext;
  sfm_arr_t            r_sfm;
  logic [N_ELEM-1:0]   r_mask;
  logic [N_ELEM-1:0]   w_maskNext;
  logic [W_CODE-1:0]   r_cnt;
  logic [W_CODE-1:0]   w_cntNext;
  logic [N_ELEM-1:0]   r_sv;
  logic [N_ELEM-1:0]   w_svNext;
  logic                r_svValid;
  logic                w_svValidNext;
  logic                r_satErr;
  logic                w_satErrNext;
  logic                w_load;
  logic [2:0]          w_pickIdx;
  logic [N_ELEM-1:0]   w_pickOnehot;
  logic [N_ELEM-1:0]   w_maskPick;

  argmax6_masked u_argmax (
    .i_vals   (r_sfm),
    .i_mask   (r_mask),
    .o_idx    (w_pickIdx),
    .o_onehot (w_pickOnehot)
  );

  // Mask after taking this cycle's pick.
  always_comb begin
    w_maskPick            = r_mask;
    w_maskPick[w_pickIdx] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and datapath control. r_cnt counts the elements still to
  // pick; the sample completes in the same cycle as the last pick, so a
  // count of k costs k cycles in SEL (one cycle when k is zero).
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_maskNext    = r_mask;
    w_svNext      = r_sv;
    w_svValidNext = 1'b0;
    w_satErrNext  = r_satErr;
    w_load        = 1'b0;
    in_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_cntNext   = clampCode(code);
          w_maskNext  = '0;
          w_stateNext = SEL;
          if (code > CODE_MAX) begin
            w_satErrNext = 1'b1;
          end
        end
      end
      SEL: begin
        if (r_cnt == '0) begin
          w_svNext      = r_mask;
          w_svValidNext = 1'b1;
          w_stateNext   = IDLE;
        end else begin
          w_maskNext = w_maskPick;
          w_cntNext  = r_cnt - 1'b1;
          if (r_cnt == W_CODE'(1)) begin
            w_svNext      = r_mask | w_pickOnehot;
            w_svValidNext = 1'b1;
            w_stateNext   = IDLE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Snapshot, mask, count and output registers. The snapshot is only
  // written on accept, so SFM movement during SEL cannot leak into the
  // sample in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sfm     <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_sv      <= '0;
      r_svValid <= 1'b0;
      r_satErr  <= 1'b0;
    end else begin
      if (w_load) begin
        r_sfm <= {sfm5, sfm4, sfm3, sfm2, sfm1, sfm0};
      end
      r_mask    <= w_maskNext;
      r_cnt     <= w_cntNext;
      r_sv      <= w_svNext;
      r_svValid <= w_svValidNext;
      r_satErr  <= w_satErrNext;
    end
  end

  assign sv       = r_sv;
  assign sv_valid = r_svValid;
  assign sat_err  = r_satErr;

endmodule

// File: tb/tb_vq6_element_selector.sv
// ---------------------------------------------------------------------------
// tb_vq6_element_selector
// Self-checking bench for vq6_element_selector: directed vector table,
// reset corner cases and a long randomized back-to-back run against a
// rank-based reference model.
// ---------------------------------------------------------------------------
module tb_vq6_element_selector;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic [5:0] sfm5, sfm4, sfm3, sfm2, sfm1, sfm0;
  logic [5:0] sv;
  logic       sv_valid;
  logic       sat_err;

  int nChecks = 0;
  int nFails  = 0;

  typedef logic [5:0][5:0] vals_t;

  typedef struct {
    logic [2:0] code;
    vals_t      vals;
    logic [5:0] expSv;
    int         expLat;
    logic       expSat;
  } vec_t;

  vec_t vecs [9];

  vq6_element_selector dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .code     (code),
    .sfm5     (sfm5),
    .sfm4     (sfm4),
    .sfm3     (sfm3),
    .sfm2     (sfm2),
    .sfm1     (sfm1),
    .sfm0     (sfm0),
    .sv       (sv),
    .sv_valid (sv_valid),
    .sat_err  (sat_err)
  );

  always #5 clk = ~clk;

  // Element i is on when fewer than k other elements outrank it, where an
  // element outranks i if it is larger, or equal with a lower index.
  function automatic logic [5:0] modelSv(input logic [2:0] c, input vals_t v);
    int k;
    logic [5:0] r;
    k = (c > 3'd6) ? 6 : int'(c);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      int beaten;
      beaten = 0;
      for (int j = 0; j < 6; j++) begin
        if ((v[j] > v[i]) || ((v[j] == v[i]) && (j < i))) beaten++;
      end
      if (beaten < k) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int popCount(input logic [5:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic vals_t randVals();
    vals_t v;
    for (int i = 0; i < 6; i++) v[i] = 6'($urandom_range(0, 63));
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic driveVals(input vals_t v);
    sfm0 = v[0];
    sfm1 = v[1];
    sfm2 = v[2];
    sfm3 = v[3];
    sfm4 = v[4];
    sfm5 = v[5];
  endtask

  // Presents one sample at a negedge while the DUT is idle, scrambles the
  // inputs right after the accept edge, and returns when sv_valid is seen.
  task automatic applyStimulus(input logic [2:0] c, input vals_t v,
                               output logic [5:0] gotSv, output int gotLat,
                               output logic readyAfterAccept, output logic readyAtValid);
    int waitCnt;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("idle_before_sample", int'(in_ready), 1);
    in_valid = 1'b1;
    code     = c;
    driveVals(v);
    @(negedge clk);
    in_valid = 1'b0;
    code     = 3'($urandom_range(0, 7));
    driveVals(randVals());
    readyAfterAccept = in_ready;
    gotLat           = -1;
    gotSv            = '0;
    readyAtValid     = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sv_valid) begin
        gotLat       = cyc;
        gotSv        = sv;
        readyAtValid = in_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] gotSv;
    int         gotLat;
    logic       rdyA, rdyV;
    logic [5:0] q [$];
    logic [5:0] lastSv;
    logic       prevValid;
    logic       sawSat;
    logic       midValid;
    int         pushed;
    int         cycles;

    vecs[0] = '{3'd0, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6},        6'b000000, 1, 1'b0};
    vecs[1] = '{3'd3, {6'd10, 6'd40, 6'd7, 6'd40, 6'd3, 6'd25},    6'b010101, 3, 1'b0};
    vecs[2] = '{3'd2, {6'd5, 6'd5, 6'd5, 6'd5, 6'd5, 6'd5},        6'b000011, 2, 1'b0};
    vecs[3] = '{3'd6, {6'd63, 6'd0, 6'd17, 6'd9, 6'd44, 6'd2},     6'b111111, 6, 1'b0};
    vecs[4] = '{3'd1, {6'd3, 6'd9, 6'd9, 6'd1, 6'd0, 6'd2},        6'b001000, 1, 1'b0};
    vecs[5] = '{3'd4, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},        6'b001111, 4, 1'b0};
    vecs[6] = '{3'd5, {6'd0, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63},   6'b011111, 5, 1'b0};
    vecs[7] = '{3'd7, {6'd12, 6'd34, 6'd56, 6'd1, 6'd2, 6'd3},     6'b111111, 6, 1'b1};
    vecs[8] = '{3'd1, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6},        6'b000001, 1, 1'b1};

    rstn     = 1'b0;
    in_valid = 1'b0;
    code     = '0;
    driveVals('0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("reset_sv",       int'(sv),       0);
    checkOutput("reset_sv_valid", int'(sv_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_sat_err",  int'(sat_err),  0);

    $display("[TB] directed vectors");
    for (int n = 0; n < 9; n++) begin
      applyStimulus(vecs[n].code, vecs[n].vals, gotSv, gotLat, rdyA, rdyV);
      checkOutput($sformatf("vec%0d_sv", n),          int'(gotSv), int'(vecs[n].expSv));
      checkOutput($sformatf("vec%0d_model", n),       int'(gotSv), int'(modelSv(vecs[n].code, vecs[n].vals)));
      checkOutput($sformatf("vec%0d_latency", n),     gotLat,      vecs[n].expLat);
      checkOutput($sformatf("vec%0d_busy", n),        int'(rdyA),  0);
      checkOutput($sformatf("vec%0d_ready_at_sv", n), int'(rdyV),  1);
      checkOutput($sformatf("vec%0d_sat_err", n),     int'(sat_err), int'(vecs[n].expSat));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_pulse", n), int'(sv_valid), 0);
      checkOutput($sformatf("vec%0d_hold", n),  int'(sv),       int'(vecs[n].expSv));
    end

    $display("[TB] reset during selection");
    in_valid = 1'b1;
    code     = 3'd6;
    driveVals(randVals());
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midsel_reset_sv",      int'(sv),       0);
    checkOutput("midsel_reset_sat_err", int'(sat_err),  0);
    @(negedge clk);
    rstn     = 1'b1;
    midValid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (sv_valid) midValid = 1'b1;
    end
    checkOutput("midsel_no_sv_valid", int'(midValid), 0);
    checkOutput("midsel_in_ready",    int'(in_ready), 1);
    checkOutput("midsel_sv",          int'(sv),       0);

    $display("[TB] randomized back-to-back run");
    pushed    = 0;
    cycles    = 0;
    lastSv    = sv;
    prevValid = 1'b0;
    sawSat    = 1'b0;
    while ((pushed < 10000 || q.size() != 0) && cycles < 80000) begin
      if (sv_valid) begin
        if (q.size() == 0) begin
          checkOutput("rand_sv_valid_without_accept", 1, 0);
        end else begin
          logic [2:0] expCode;
          logic [5:0] expSv;
          expSv   = q.pop_front();
          expCode = 3'(popCount(expSv));
          checkOutput("rand_sv", int'(sv), int'(expSv));
          checkOutput("rand_popcount", popCount(sv), int'(expCode));
        end
        checkOutput("rand_single_pulse", int'(prevValid), 0);
        lastSv = sv;
      end else if (sv !== lastSv) begin
        checkOutput("rand_sv_hold", int'(sv), int'(lastSv));
        lastSv = sv;
      end
      prevValid = sv_valid;
      if (pushed < 10000) begin
        vals_t v;
        v        = randVals();
        in_valid = ($urandom_range(0, 9) != 0);
        code     = 3'($urandom_range(0, 7));
        driveVals(v);
        if (in_valid && in_ready) begin
          q.push_back(modelSv(code, v));
          if (code > 3'd6) sawSat = 1'b1;
          pushed++;
        end
      end else begin
        in_valid = 1'b0;
        driveVals(randVals());
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("rand_samples_done", pushed,   10000);
    checkOutput("rand_queue_drained", q.size(), 0);
    checkOutput("rand_sat_err",      int'(sat_err), int'(sawSat));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
